// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: access-type encoding, FSM states
// and the lane helpers used to build byte enables and store data.
package mem_pkg;

  localparam logic [2:0] MEMOP_NONE = 3'b000;
  localparam logic [2:0] MEMOP_W    = 3'b001;
  localparam logic [2:0] MEMOP_B    = 3'b010;
  localparam logic [2:0] MEMOP_BU   = 3'b011;
  localparam logic [2:0] MEMOP_H    = 3'b100;
  localparam logic [2:0] MEMOP_HU   = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  // Encodings 110 and 111 are reserved and behave like NONE.
  function automatic logic op_is_access(input logic [2:0] op);
    return (op != MEMOP_NONE) && (op <= MEMOP_HU);
  endfunction

  function automatic logic op_is_misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op)
      MEMOP_W:           return off != 2'b00;
      MEMOP_H, MEMOP_HU: return off[0];
      default:           return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_enable(input logic [2:0] op, input logic [1:0] off);
    case (op)
      MEMOP_W:           return 4'b1111;
      MEMOP_B, MEMOP_BU: return 4'b0001 << off;
      MEMOP_H, MEMOP_HU: return off[1] ? 4'b1100 : 4'b0011;
      default:           return 4'b0000;
    endcase
  endfunction

  // Replicate the store operand across every lane it could land in.
  function automatic logic [31:0] store_lanes(input logic [2:0] op, input logic [31:0] data);
    case (op)
      MEMOP_B, MEMOP_BU: return {4{data[7:0]}};
      MEMOP_H, MEMOP_HU: return {2{data[15:0]}};
      default:           return data;
    endcase
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Picks the addressed byte/half out of a little-endian read word and
// sign- or zero-extends it to 32 bits.
module load_align_ext
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  mem_op,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (byte_off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (mem_op)
      MEMOP_B:  result = {{24{byte_sel[7]}}, byte_sel};
      MEMOP_BU: result = {24'd0, byte_sel};
      MEMOP_H:  result = {{16{half_sel[15]}}, half_sel};
      MEMOP_HU: result = {16'd0, half_sel};
      default:  result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one data-memory access per load/store, stalls
// the front of the pipe until it completes, and forms the writeback triple.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_regWriteEn,
  input  logic [4:0]  mem_regWriteAddr,
  input  logic [31:0] mem_regWriteData,
  input  logic        mem_memWriteEn,
  input  logic [2:0]  mem_memOp,
  input  logic [31:0] mem_regData2,
  input  logic [31:0] mem_memAddr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        wb_regWriteEn,
  output logic [4:0]  wb_regWriteAddr,
  output logic [31:0] wb_regWriteData,
  output logic        mem_addrErr,
  output logic        mem_busErr,
  output mem_state_e  dbg_state,
  output logic [31:0] dbg_rdata_q
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  mem_state_e    state_q, state_d;
  logic [CW-1:0] wait_cnt_q;
  logic [31:0]   rdata_q;
  logic [31:0]   load_result;
  logic          is_access, is_store, is_load, misaligned;
  logic          start_req, timeout;

  always_comb begin
    is_access  = op_is_access(mem_memOp);
    is_store   = is_access & mem_memWriteEn;
    is_load    = is_access & ~mem_memWriteEn;
    misaligned = is_access & op_is_misaligned(mem_memOp, mem_memAddr[1:0]);
    timeout    = (state_q == WAIT) && !dmem_ack && (wait_cnt_q == CW'(MAX_WAIT - 1));
  end

  // Handshake: dmem_req rises with all dmem_* fields and they stay frozen
  // until the single-cycle dmem_ack is sampled in WAIT (or the wait times
  // out); acks outside WAIT carry no meaning and are dropped.
  always_comb begin
    state_d     = state_q;
    mem_stall   = 1'b0;
    mem_addrErr = 1'b0;
    start_req   = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_access) begin
          if (misaligned) begin
            mem_addrErr = 1'b1;
          end else begin
            mem_stall = 1'b1;
            start_req = 1'b1;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (dmem_ack || timeout) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      dmem_be    <= 4'd0;
      mem_busErr <= 1'b0;
      wait_cnt_q <= '0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      mem_busErr <= timeout;
      if (start_req) begin
        dmem_req   <= 1'b1;
        dmem_we    <= is_store;
        dmem_addr  <= {mem_memAddr[31:2], 2'b00};
        dmem_wdata <= store_lanes(mem_memOp, mem_regData2);
        dmem_be    <= is_store ? lane_enable(mem_memOp, mem_memAddr[1:0]) : 4'b1111;
        wait_cnt_q <= '0;
      end else if (state_q == WAIT) begin
        if (dmem_ack) begin
          rdata_q  <= dmem_rdata;
          dmem_req <= 1'b0;
        end else if (timeout) begin
          dmem_req <= 1'b0;
        end else begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
        end
      end
    end
  end

  load_align_ext u_load_align_ext (
    .rdata    (rdata_q),
    .byte_off (mem_memAddr[1:0]),
    .mem_op   (mem_memOp),
    .result   (load_result)
  );

  // mem_busErr is only ever high in the DONE cycle that follows an abort.
  assign wb_regWriteAddr = mem_regWriteAddr;
  assign wb_regWriteEn   = mem_regWriteEn & ~mem_stall & ~mem_addrErr & ~mem_busErr;
  assign wb_regWriteData = (state_q == DONE && is_load) ? load_result : mem_regWriteData;

  assign dbg_state   = state_q;
  assign dbg_rdata_q = rdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed and random loads/stores against a
// plain-arithmetic model, with a memory responder and a retire monitor.
module tb_mem_access_stage;
  import mem_pkg::*;

  localparam int MAX_WAIT     = 255;
  localparam int RETIRE_LIMIT = MAX_WAIT + 10;

  typedef struct packed {
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        addr_err;
    logic        bus_err;
    logic [8:0]  stall_cyc;
    logic [8:0]  req_cyc;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_regWriteEn, mem_memWriteEn;
  logic [4:0]  mem_regWriteAddr;
  logic [31:0] mem_regWriteData, mem_regData2, mem_memAddr;
  logic [2:0]  mem_memOp;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall, wb_regWriteEn, mem_addrErr, mem_busErr;
  logic [4:0]  wb_regWriteAddr;
  logic [31:0] wb_regWriteData;
  mem_state_e  dbg_state;
  logic [31:0] dbg_rdata_q;

  mem_access_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .mem_regWriteEn(mem_regWriteEn), .mem_regWriteAddr(mem_regWriteAddr),
    .mem_regWriteData(mem_regWriteData), .mem_memWriteEn(mem_memWriteEn),
    .mem_memOp(mem_memOp), .mem_regData2(mem_regData2), .mem_memAddr(mem_memAddr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .wb_regWriteEn(wb_regWriteEn),
    .wb_regWriteAddr(wb_regWriteAddr), .wb_regWriteData(wb_regWriteData),
    .mem_addrErr(mem_addrErr), .mem_busErr(mem_busErr),
    .dbg_state(dbg_state), .dbg_rdata_q(dbg_rdata_q)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          auto_resp = 1'b0;
  bit          instr_active = 1'b0;
  bit          manual_ack = 1'b0;
  logic [31:0] manual_word = 32'd0;
  int          cur_delay = 0;
  logic [31:0] cur_word = 32'd0;
  logic [EXP_W-1:0] exp_q[$];
  logic [68:0]      req_q[$];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] load_model(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] op);
    int unsigned off, v;
    off = addr % 4;
    if (op == MEMOP_B || op == MEMOP_BU) begin
      v = (word >> (8 * off)) % 256;
      if (op == MEMOP_B && v >= 128) v = v - 256;
      return v;
    end
    if (op == MEMOP_H || op == MEMOP_HU) begin
      v = (word >> (8 * (off - off % 2))) % 65536;
      if (op == MEMOP_H && v >= 32768) v = v - 65536;
      return v;
    end
    return word;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input logic rwe, input logic [4:0] rwa, input logic [31:0] alu,
                            input logic we, input logic [2:0] op, input logic [31:0] rd2,
                            input logic [31:0] addr);
    mem_regWriteEn   = rwe;
    mem_regWriteAddr = rwa;
    mem_regWriteData = alu;
    mem_memWriteEn   = we;
    mem_memOp        = op;
    mem_regData2     = rd2;
    mem_memAddr      = addr;
  endtask

  task automatic drive_none();
    set_inputs(1'b0, 5'd0, 32'd0, 1'b0, MEMOP_NONE, 32'd0, 32'd0);
  endtask

  // delay = ack arrives after this many silent WAIT cycles
  task automatic issue(input logic rwe, input logic [4:0] rwa, input logic [31:0] alu,
                       input logic we, input logic [2:0] op, input logic [31:0] rd2,
                       input logic [31:0] addr, input logic [31:0] word, input int delay);
    exp_t        e;
    bit          acc, st, mis, retired;
    int          waits;
    int unsigned off;
    logic [3:0]  be;
    logic [31:0] wd;
    off   = addr % 4;
    acc   = (op >= 3'd1 && op <= 3'd5);
    st    = acc && we;
    mis   = acc && ((op == MEMOP_W && off != 0) ||
                    ((op == MEMOP_H || op == MEMOP_HU) && off % 2 != 0));
    waits = (delay + 1 > MAX_WAIT) ? MAX_WAIT : delay + 1;
    e.wb_addr  = rwa;
    e.addr_err = mis;
    e.wb_data  = alu;
    if (!acc || mis) begin
      e.wb_en = rwe && !mis;
      e.bus_err = 1'b0;
      e.stall_cyc = 9'd0;
      e.req_cyc = 9'd0;
    end else begin
      e.bus_err   = (delay + 1 > MAX_WAIT);
      e.wb_en     = rwe && !e.bus_err;
      e.stall_cyc = 9'(1 + waits);
      e.req_cyc   = 9'(waits);
      if (!st) e.wb_data = load_model(word, addr, op);
      if (!st || op == MEMOP_W) be = 4'hF;
      else if (op == MEMOP_B || op == MEMOP_BU) be = 4'(1 << off);
      else be = (off >= 2) ? 4'hC : 4'h3;
      if (op == MEMOP_B || op == MEMOP_BU) wd = (rd2 % 256) * 32'h0101_0101;
      else if (op == MEMOP_H || op == MEMOP_HU) wd = (rd2 % 65536) * 32'h0001_0001;
      else wd = rd2;
      req_q.push_back({st, be, addr & 32'hFFFF_FFFC, wd});
    end
    if (!e.wb_en) e.wb_data = 32'd0;
    exp_q.push_back(EXP_W'(e));
    cur_delay = delay;
    cur_word  = word;
    set_inputs(rwe, rwa, alu, we, op, rd2, addr);
    instr_active = 1'b1;
    retired = 1'b0;
    for (int n = 0; n < RETIRE_LIMIT; n++) begin
      @(negedge clk);
      if (!mem_stall) begin
        retired = 1'b1;
        break;
      end
    end
    check("retire_in_time", 96'(retired), 96'(1));
    @(posedge clk);
    #1;
  endtask

  // ---------------- memory responder ----------------
  int          resp_k = 0;
  logic [68:0] resp_first;

  initial begin : responder
    logic [68:0] exp_req, act_req;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = $urandom;
      act_req    = {dmem_we, dmem_be, dmem_addr, dmem_wdata};
      if (!auto_resp) begin
        resp_k = 0;
        if (manual_ack) begin
          dmem_ack   = 1'b1;
          dmem_rdata = manual_word;
        end
      end else if (dmem_req) begin
        resp_k++;
        if (resp_k == 1) begin
          resp_first = act_req;
          if (req_q.size() > 0) begin
            exp_req = req_q.pop_front();
            check("req_ctrl", 96'(act_req[68:32]), 96'(exp_req[68:32]));
            if (exp_req[68]) check("req_wdata", 96'(act_req[31:0]), 96'(exp_req[31:0]));
          end
        end else begin
          check("req_stable", 96'(act_req), 96'(resp_first));
        end
        if (resp_k == cur_delay + 1) begin
          dmem_ack   = 1'b1;
          dmem_rdata = cur_word;
        end
      end else begin
        resp_k = 0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    exp_t e;
    int   stall_cnt;
    int   req_cnt;
    stall_cnt = 0;
    req_cnt   = 0;
    forever begin
      @(negedge clk);
      if (instr_active) begin
        if (dmem_req) req_cnt++;
        if (mem_stall) begin
          stall_cnt++;
          check("stall_quiet", 96'({wb_regWriteEn, mem_addrErr, mem_busErr}), 96'(0));
        end else begin
          check("sb_nonempty", 96'(exp_q.size() > 0), 96'(1));
          if (exp_q.size() > 0) begin
            e = exp_t'(exp_q.pop_front());
            check("wb_en", 96'(wb_regWriteEn), 96'(e.wb_en));
            check("wb_addr", 96'(wb_regWriteAddr), 96'(e.wb_addr));
            check("wb_data", 96'(wb_regWriteEn ? wb_regWriteData : 32'd0), 96'(e.wb_data));
            check("addr_err", 96'(mem_addrErr), 96'(e.addr_err));
            check("bus_err", 96'(mem_busErr), 96'(e.bus_err));
            check("stall_cycles", 96'(stall_cnt), 96'(e.stall_cyc));
            check("req_cycles", 96'(req_cnt), 96'(e.req_cyc));
          end
          stall_cnt = 0;
          req_cnt   = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    logic [2:0]  op;
    logic        we;
    int          d;
    rst = 1'b1;
    drive_none();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 96'(dbg_state), 96'(IDLE));
    check("rst_ctrl", 96'({dmem_req, dmem_we, dmem_be, mem_busErr, mem_stall}), 96'(0));
    check("rst_addr_wdata", 96'({dmem_addr, dmem_wdata}), 96'(0));
    check("rst_rdata_q", 96'(dbg_rdata_q), 96'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    auto_resp = 1'b1;

    issue(1'b1, 5'd1, 32'h1, 1'b0, MEMOP_W,  32'd0, 32'h100, 32'h8899_AABB, 0);
    issue(1'b1, 5'd2, 32'h2, 1'b0, MEMOP_B,  32'd0, 32'h103, 32'h8011_2233, 0);
    issue(1'b1, 5'd3, 32'h3, 1'b0, MEMOP_BU, 32'd0, 32'h103, 32'h8011_2233, 0);
    issue(1'b1, 5'd4, 32'h4, 1'b0, MEMOP_H,  32'd0, 32'h102, 32'h8011_2233, 0);
    issue(1'b1, 5'd5, 32'h5, 1'b0, MEMOP_HU, 32'd0, 32'h102, 32'h8011_2233, 0);
    issue(1'b0, 5'd0, 32'h6, 1'b1, MEMOP_B,  32'h0000_00A5, 32'h101, 32'd0, 0);
    issue(1'b0, 5'd0, 32'h7, 1'b1, MEMOP_H,  32'h1234_BEEF, 32'h102, 32'd0, 1);
    issue(1'b1, 5'd8, 32'h8, 1'b0, MEMOP_W,  32'd0, 32'h102, 32'h1111_1111, 0);
    issue(1'b1, 5'd9, 32'h9, 1'b0, MEMOP_HU, 32'd0, 32'h101, 32'h1111_1111, 0);
    issue(1'b1, 5'd10, 32'hCAFE, 1'b1, 3'b110, 32'hFFFF_FFFF, 32'h100, 32'd0, 0);
    issue(1'b1, 5'd11, 32'hB, 1'b0, MEMOP_W, 32'd0, 32'h104, 32'h0BAD_F00D, 4);
    issue(1'b1, 5'd12, 32'hC, 1'b0, MEMOP_W, 32'd0, 32'h108, 32'h5555_AAAA, MAX_WAIT - 1);
    issue(1'b1, 5'd13, 32'hD, 1'b0, MEMOP_W, 32'd0, 32'h10C, 32'h7777_7777, MAX_WAIT);
    issue(1'b1, 5'd14, 32'hE, 1'b1, MEMOP_W, 32'h1357_9BDF, 32'h110, 32'd0, 100000);
    issue(1'b1, 5'd15, 32'h0000_0ADD, 1'b0, MEMOP_NONE, 32'd0, 32'h0, 32'd0, 0);
    issue(1'b1, 5'd16, 32'h10, 1'b0, MEMOP_W, 32'd0, 32'h200, 32'hFEDC_BA98, 0);

    for (int i = 0; i < 160; i++) begin
      op = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 59) == 0) ? MAX_WAIT + 3 : int'($urandom_range(0, 6));
      issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, we, op,
            $urandom, $urandom, $urandom, d);
      if ($urandom_range(0, 3) == 0) begin
        instr_active = 1'b0;
        drive_none();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    // reset while a load is outstanding, then a late ack
    instr_active = 1'b0;
    auto_resp    = 1'b0;
    set_inputs(1'b1, 5'd9, 32'd0, 1'b0, MEMOP_W, 32'd0, 32'h200);
    @(negedge clk);
    check("rstw_stall", 96'(mem_stall), 96'(1));
    @(negedge clk);
    check("rstw_in_wait", 96'({dmem_req, dbg_state}), 96'({1'b1, WAIT}));
    @(posedge clk);
    #1 rst = 1'b1;
    drive_none();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstw_req_drop", 96'({dmem_req, dbg_state}), 96'({1'b0, IDLE}));
    @(posedge clk);
    #1 manual_word = 32'hDEAD_BEEF;
    manual_ack = 1'b1;
    @(posedge clk);
    #1 manual_ack = 1'b0;
    @(posedge clk);
    #1;
    check("late_ack_rdata_q", 96'(dbg_rdata_q), 96'(0));
    check("late_ack_state", 96'({dmem_req, dbg_state, mem_stall}), 96'({1'b0, IDLE, 1'b0}));
    check("sb_drained", 96'(exp_q.size()), 96'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage. Consumes the EX/MEM register outputs and drives a request/acknowledge data-memory port with variable latency.
- Stalls the pipeline while an access is outstanding.
- Aligns and extends load data, and presents the writeback triple to the MEM/WB register.
- Misaligned accesses are detected, flagged and suppressed.

Parameters:
- MAX_WAIT, 255: cycles in WAIT without dmem_ack before abort with mem_busErr. Counter width is clog2(MAX_WAIT+1).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous reset, active-high
- mem_regWriteEn  in  1  from EX/MEM
- mem_regWriteAddr  in  5  from EX/MEM
- mem_regWriteData  in  32  ALU result from EX/MEM
- mem_memWriteEn  in  1  store flag
- mem_memOp  in  3  access type (encoding in package)
- mem_regData2  in  32  store data
- mem_memAddr  in  32  byte address
- dmem_req  out  1  request, registered
- dmem_we  out  1  write strobe, registered
- dmem_addr  out  32  word address ({addr[31:2],2'b00}), registered
- dmem_wdata  out  32  lane-replicated store data, registered
- dmem_be  out  4  byte enables, registered
- dmem_ack  in  1  one-cycle completion pulse
- dmem_rdata  in  32  read word; valid with ack
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- wb_regWriteEn  out  1  to MEM/WB
- wb_regWriteAddr  out  5  to MEM/WB
- wb_regWriteData  out  32  to MEM/WB
- mem_addrErr  out  1  misaligned-access pulse
- mem_busErr  out  1  timeout pulse

Behaviour:
- memOp encoding: 000 NONE, 001 W, 010 B, 011 BU, 100 H, 101 HU; 110 and 111 are treated as NONE.
- Store = memWriteEn and op≠NONE. BU/HU on a store act as B/H.
- Load = !memWriteEn and op≠NONE.
- Misaligned: W with addr[1:0]≠0, or H/HU with addr[0]≠0.
- Little-endian lanes. Byte enables:
  - B: be = 1<<addr[1:0]
  - H: be = 0011 or 1100
  - W: be = 1111
  - Loads drive be=1111.
- Store data: byte replicated ×4, half replicated ×2.
- Load extract by addr[1:0]. B/H are sign-extended; BU/HU are zero-extended.
- FSM states: IDLE, WAIT, DONE.
  - IDLE, aligned access present: mem_stall=1 combinationally. Register dmem_req=1 plus we/addr/wdata/be. Go to WAIT.
  - IDLE, misaligned access: mem_addrErr=1 for that cycle, no request, no stall, wb_regWriteEn=0. Stay in IDLE.
  - IDLE, op NONE: pass-through with no stall.
  - WAIT: mem_stall=1. Hold all dmem_* stable. On dmem_ack: capture dmem_rdata into rdata_q, drop dmem_req, go to DONE. The ack is accepted in the same cycle it arrives.
  - WAIT timeout: if the wait counter reaches MAX_WAIT without ack, drop dmem_req, pulse mem_busErr for 1 cycle, go to DONE with wb_regWriteEn forced 0.
  - DONE: mem_stall=0. Outputs present the completed result. EX/MEM advances at this edge. Go to IDLE unconditionally.
- Minimum latency: 3 cycles per memory access (ack in the first WAIT cycle). Non-memory instructions add 0 cycles.
- Writeback outputs are combinational:
  - wb_regWriteAddr = mem_regWriteAddr.
  - wb_regWriteEn = mem_regWriteEn & !mem_stall & !(misaligned in IDLE) & !(timeout abort).
  - wb_regWriteData = extended rdata_q in DONE for a load; otherwise mem_regWriteData.
- While mem_stall=1, wb_regWriteEn=0, so MEM/WB latches a bubble.
- Reset (any state): state→IDLE; dmem_req, dmem_we, dmem_be, mem_busErr, wait counter → 0; dmem_addr, dmem_wdata, rdata_q → 0.
- Reset mid-WAIT: the request drops at the next edge. A late dmem_ack in IDLE is ignored.
- A spurious dmem_ack in IDLE or DONE is ignored; rdata_q is unchanged.
- Inputs are assumed stable while mem_stall=1, since EX/MEM is frozen.

Decomposition:
- Shared package mem_pkg holds:
  - MEMOP_* localparams for the encoding above
  - FSM state encodings IDLE/WAIT/DONE
  - the lane-enable function
- One natural sub-module, load_align_ext: combinational extract and extend (rdata, addr[1:0], memOp → 32-bit result). It is reusable by a future cache.

Test Plan:
- LW at addr 0x100, memory word 0x8899AABB, ack in the 1st WAIT cycle.
  - Expect mem_stall high for exactly 2 cycles, then wb_regWriteData=0x8899AABB with wb_regWriteEn=1 in DONE.
- LB at 0x103, word 0x80112233.
  - Expect wb_regWriteData=0xFFFFFF80.
  - LBU at the same address: expect 0x00000080.
  - LH at 0x102: expect 0xFFFF8011.
  - LHU at 0x102: expect 0x00008011.
- SB at 0x101 with regData2=0x000000A5.
  - Expect dmem_we=1, dmem_be=0010, dmem_wdata=0xA5A5A5A5, dmem_addr=0x100.
  - SH at 0x102: expect be=1100.
- LW at 0x102.
  - Expect mem_addrErr pulse, dmem_req never asserted, no stall, wb_regWriteEn=0.
- Ack delayed 5 cycles: stall holds for 6 cycles with dmem_* stable.
  - With ack withheld for MAX_WAIT cycles: expect mem_busErr pulse, wb_regWriteEn=0, return to IDLE.
- Assert rst during WAIT, then deliver ack 2 cycles later.
  - Expect dmem_req=0 after reset, state IDLE, ack ignored, rdata_q=0.
  - Back-to-back ADD then LW: ADD passes with zero added cycles.
